// File: rtl/echo_mix_operator.sv
// rtl/echo_mix_operator.sv - delay-line operator: wet mix and feedback write-back
// Two shift-add multipliers share one serial pass over the gain bits, LSB first.
module echo_mix_operator #(
  parameter int audio_width = 16,
  parameter int gain_width  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic [audio_width-1:0] i_current,
  input  logic [audio_width-1:0] i_buffer,
  input  logic [gain_width-1:0]  i_mix_gain,
  input  logic [gain_width-1:0]  i_feedback_gain,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [audio_width-1:0] o_result,
  output logic [audio_width-1:0] o_buffer
);

  localparam int AccW = audio_width + gain_width;
  localparam int CntW = $clog2(gain_width + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(gain_width - 1);

  typedef enum logic [1:0] {IDLE, MUL, SUM, OUT} state_t;

  state_t                  state_q, state_d;
  logic [audio_width-1:0]  cur_q, cur_d;
  logic [audio_width-1:0]  buf_q, buf_d;
  logic [gain_width-1:0]   mix_g_q, mix_g_d;
  logic [gain_width-1:0]   fb_g_q, fb_g_d;
  logic [AccW-1:0]         acc_mix_q, acc_mix_d;
  logic [AccW-1:0]         acc_fb_q, acc_fb_d;
  logic [CntW-1:0]         count_q, count_d;
  logic                    valid_q, valid_d;
  logic [audio_width-1:0]  result_q, result_d;
  logic [audio_width-1:0]  wb_q, wb_d;

  logic [AccW-1:0]         buf_ext;
  logic [AccW-1:0]         addend;
  logic [gain_width-1:0]   mix_sh;
  logic [gain_width-1:0]   fb_sh;

  // Sum at one extra bit; disagreeing top bits mean overflow in that direction.
  function automatic logic [audio_width-1:0] sat_add(input logic [audio_width-1:0] a,
                                                     input logic [audio_width-1:0] b);
    logic [audio_width:0] s;
    s = {a[audio_width-1], a} + {b[audio_width-1], b};
    if (s[audio_width] != s[audio_width-1])
      sat_add = s[audio_width] ? {1'b1, {(audio_width-1){1'b0}}}
                               : {1'b0, {(audio_width-1){1'b1}}};
    else
      sat_add = s[audio_width-1:0];
  endfunction

  assign buf_ext = {{gain_width{buf_q[audio_width-1]}}, buf_q};
  assign addend  = buf_ext << count_q;
  assign mix_sh  = mix_g_q >> count_q;
  assign fb_sh   = fb_g_q >> count_q;

  assign i_ready  = (state_q == IDLE);
  assign o_valid  = valid_q;
  assign o_result = result_q;
  assign o_buffer = wb_q;

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    buf_d     = buf_q;
    mix_g_d   = mix_g_q;
    fb_g_d    = fb_g_q;
    acc_mix_d = acc_mix_q;
    acc_fb_d  = acc_fb_q;
    count_d   = count_q;
    valid_d   = valid_q;
    result_d  = result_q;
    wb_d      = wb_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          cur_d     = i_current;
          buf_d     = i_buffer;
          mix_g_d   = i_mix_gain;
          fb_g_d    = i_feedback_gain;
          acc_mix_d = '0;
          acc_fb_d  = '0;
          count_d   = '0;
          state_d   = MUL;
        end
      end
      MUL: begin
        if (mix_sh[0]) acc_mix_d = acc_mix_q + addend;
        if (fb_sh[0])  acc_fb_d  = acc_fb_q + addend;
        count_d = count_q + CntW'(1);
        if (count_q == LastCnt) state_d = SUM;
      end
      SUM: begin
        // Dropping the low gain_width bits is the floor-rounding arithmetic shift.
        result_d = sat_add(cur_q, acc_mix_q[AccW-1:gain_width]);
        wb_d     = sat_add(cur_q, acc_fb_q[AccW-1:gain_width]);
        valid_d  = 1'b1;
        state_d  = OUT;
      end
      OUT: begin
        if (o_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      buf_q     <= '0;
      mix_g_q   <= '0;
      fb_g_q    <= '0;
      acc_mix_q <= '0;
      acc_fb_q  <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      result_q  <= '0;
      wb_q      <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      buf_q     <= buf_d;
      mix_g_q   <= mix_g_d;
      fb_g_q    <= fb_g_d;
      acc_mix_q <= acc_mix_d;
      acc_fb_q  <= acc_fb_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      result_q  <= result_d;
      wb_q      <= wb_d;
    end
  end

endmodule

// File: tb/tb_echo_mix_operator.sv
// tb/tb_echo_mix_operator.sv - randomized and directed checks of echo_mix_operator
module tb_echo_mix_operator;
  localparam int AW = 16;
  localparam int GW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_ready;
  logic [AW-1:0] i_current = '0;
  logic [AW-1:0] i_buffer = '0;
  logic [GW-1:0] i_mix_gain = '0;
  logic [GW-1:0] i_feedback_gain = '0;
  logic          o_valid;
  logic          o_ready = 1'b0;
  logic [AW-1:0] o_result;
  logic [AW-1:0] o_buffer;

  always #5 clk = ~clk;

  echo_mix_operator #(.audio_width(AW), .gain_width(GW)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_ready(i_ready),
    .i_current(i_current), .i_buffer(i_buffer),
    .i_mix_gain(i_mix_gain), .i_feedback_gain(i_feedback_gain),
    .o_valid(o_valid), .o_ready(o_ready),
    .o_result(o_result), .o_buffer(o_buffer)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // current + floor(buffer * gain / 2^GW), clamped to the signed sample range
  function automatic logic [AW-1:0] model(input logic [AW-1:0] c, input logic [AW-1:0] b,
                                          input logic [GW-1:0] g);
    longint p, s, hi, lo;
    hi = (longint'(1) <<< (AW - 1)) - 1;
    lo = -(longint'(1) <<< (AW - 1));
    p = longint'($signed(b)) * longint'(g);
    p = p >>> GW;
    s = longint'($signed(c)) + p;
    if (s > hi) s = hi;
    else if (s < lo) s = lo;
    model = s[AW-1:0];
  endfunction

  typedef struct {
    logic [AW-1:0] r;
    logic [AW-1:0] b;
    int            acc;
  } exp_t;

  exp_t          q[$];
  logic          was_valid = 1'b0;
  logic [AW-1:0] held_r = '0;
  logic [AW-1:0] held_b = '0;

  always @(negedge clk) begin
    if (!reset) begin
      chk("reset_o_valid", 32'(o_valid), 32'd0);
      chk("reset_i_ready", 32'(i_ready), 32'd1);
      chk("reset_o_result", 32'(o_result), 32'd0);
      chk("reset_o_buffer", 32'(o_buffer), 32'd0);
      q.delete();
      was_valid = 1'b0;
    end else begin
      if (i_valid && i_ready)
        q.push_back('{model(i_current, i_buffer, i_mix_gain),
                      model(i_current, i_buffer, i_feedback_gain), cyc + 1});
      if (o_valid && !was_valid) begin
        if (q.size() == 0) chk("unexpected_o_valid", 32'd1, 32'd0);
        else begin
          chk("o_result", 32'(o_result), 32'(q[0].r));
          chk("o_buffer", 32'(o_buffer), 32'(q[0].b));
          chk("latency", 32'(cyc - q[0].acc), 32'(GW + 1));
        end
        held_r = o_result;
        held_b = o_buffer;
      end else if (o_valid) begin
        chk("hold_o_result", 32'(o_result), 32'(held_r));
        chk("hold_o_buffer", 32'(o_buffer), 32'(held_b));
      end
      if (o_valid) chk("i_ready_busy", 32'(i_ready), 32'd0);
      if (!o_valid && was_valid) begin
        chk("i_ready_after_handshake", 32'(i_ready), 32'd1);
        if (q.size() > 0) q.delete(0);
      end
      was_valid = o_valid;
    end
  end

  task automatic run(input logic [AW-1:0] c, input logic [AW-1:0] b,
                     input logic [GW-1:0] mg, input logic [GW-1:0] fg, input int hold,
                     output logic [AW-1:0] r, output logic [AW-1:0] ob);
    int n;
    i_current = c; i_buffer = b; i_mix_gain = mg; i_feedback_gain = fg; i_valid = 1'b1;
    @(negedge clk);
    n = 0;
    while (!i_ready && n < 100) begin @(negedge clk); n++; end
    if (!i_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_current = AW'($urandom); i_buffer = AW'($urandom);
    i_mix_gain = GW'($urandom); i_feedback_gain = GW'($urandom);
    @(negedge clk);
    n = 0;
    while (!o_valid && n < 100) begin @(negedge clk); n++; end
    if (!o_valid) chk("result_timeout", 32'd0, 32'd1);
    r = o_result;
    ob = o_buffer;
    repeat (hold) @(negedge clk);
    #1 o_ready = 1'b1;
    @(posedge clk); #1;
    o_ready = 1'b0;
  endtask

  function automatic logic [AW-1:0] pick();
    logic [AW-1:0] v;
    case ($urandom_range(0, 5))
      0: v = 16'h7FFF;
      1: v = 16'h8000;
      2: v = 16'h0000;
      default: v = AW'($urandom);
    endcase
    pick = v;
  endfunction

  function automatic logic [GW-1:0] pick_g();
    logic [GW-1:0] v;
    case ($urandom_range(0, 4))
      0: v = '0;
      1: v = '1;
      default: v = GW'($urandom);
    endcase
    pick_g = v;
  endfunction

  logic [AW-1:0] r, ob;
  logic [AW-1:0] line [4];
  logic [AW-1:0] loop_exp [9];

  initial begin
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    chk("model_basic", 32'(model(16'h1000, 16'h2000, 8'h80)), 32'h2000);
    chk("model_wet", 32'(model(16'h0000, 16'h7000, 8'hFF)), 32'h6F90);
    chk("model_floor", 32'(model(16'h0000, 16'hFFFF, 8'h01)), 32'hFFFF);

    run(16'h1000, 16'h2000, 8'h80, 8'h40, 0, r, ob);
    chk("basic_r", 32'(r), 32'h2000); chk("basic_b", 32'(ob), 32'h1800);
    run(16'h7000, 16'h7000, 8'hFF, 8'h00, 1, r, ob);
    chk("possat_r", 32'(r), 32'h7FFF); chk("possat_b", 32'(ob), 32'h7000);
    run(16'h8000, 16'h8000, 8'hFF, 8'h00, 0, r, ob);
    chk("negsat_r", 32'(r), 32'h8000); chk("negsat_b", 32'(ob), 32'h8000);
    run(16'h0000, 16'hFFFF, 8'h80, 8'h01, 0, r, ob);
    chk("floor_r", 32'(r), 32'hFFFF); chk("floor_b", 32'(ob), 32'hFFFF);
    run(16'h1234, 16'h7FFF, 8'h00, 8'h00, 0, r, ob);
    chk("gain0_r", 32'(r), 32'h1234); chk("gain0_b", 32'(ob), 32'h1234);

    run(16'h0200, 16'h4000, 8'h40, 8'hC0, 5, r, ob);
    chk("bp_r", 32'(r), 32'h1200); chk("bp_b", 32'(ob), 32'h3200);
    run(16'h0000, 16'h4000, 8'hFF, 8'h01, 2, r, ob);
    chk("bp2_r", 32'(r), 32'h3FC0); chk("bp2_b", 32'(ob), 32'h0040);

    i_current = 16'h3000; i_buffer = 16'h3000; i_mix_gain = 8'hFF; i_feedback_gain = 8'hFF;
    i_valid = 1'b1;
    @(negedge clk);
    chk("pre_abort_ready", 32'(i_ready), 32'd1);
    @(posedge clk); #1 i_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1 chk("abort_o_valid", 32'(o_valid), 32'd0);
    chk("abort_i_ready", 32'(i_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    run(16'h0100, 16'h0000, 8'h80, 8'h80, 0, r, ob);
    chk("post_reset_r", 32'(r), 32'h0100); chk("post_reset_b", 32'(ob), 32'h0100);

    loop_exp = '{16'h1000, 16'h0, 16'h0, 16'h0, 16'h0800, 16'h0, 16'h0, 16'h0, 16'h0400};
    for (int i = 0; i < 4; i++) line[i] = '0;
    for (int i = 0; i < 9; i++) begin
      run((i == 0) ? 16'h1000 : 16'h0000, line[i % 4], 8'h80, 8'h80, 0, r, ob);
      line[i % 4] = ob;
      chk($sformatf("loop_%0d", i), 32'(r), 32'(loop_exp[i]));
    end

    for (int i = 0; i < 200; i++)
      run(pick(), pick(), pick_g(), pick_g(), $urandom_range(0, 3), r, ob);

    repeat (20) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/echo_mix_operator.md
Name: echo_mix_operator

Overview:
- Responder end of the delay buffer's operator interface.
- Per transaction it accepts one current sample and one delayed (buffer) sample, and returns two values:
  - the mixed output sample;
  - the new value to write back into the delay line.
- Both products use sequential shift-add multipliers with programmable Q0.N gains; sums saturate.
- Sits between the delay buffer's o_valid_operator/o_current/o_buffer outputs and its i_valid_result/i_result/i_buffer inputs.

Parameters:
- audio_width, 16, signed two's-complement sample width.
- gain_width, 8, unsigned fractional gain width (Q0.gain_width; gain g means g/2^gain_width).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- i_valid  input  1  operand pair valid.
- i_ready  output  1  block can accept an operand pair.
- i_current  input  audio_width  current input sample, signed.
- i_buffer  input  audio_width  delayed sample from delay line, signed.
- i_mix_gain  input  gain_width  wet gain applied to i_buffer for the output path.
- i_feedback_gain  input  gain_width  feedback gain applied to i_buffer for the write-back path.
- o_valid  output  1  result pair valid.
- o_ready  input  1  downstream accepts the result pair.
- o_result  output  audio_width  mixed output sample, signed.
- o_buffer  output  audio_width  value to write back into the delay line, signed.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, i_ready=1, o_valid=0, o_result=0, o_buffer=0, accumulators and counter cleared. Asserting reset mid-transaction aborts it; no result is produced.
- States: IDLE, MUL, SUM, OUT.
- IDLE:
  - i_ready=1.
  - On an edge with i_valid=1: latch i_current, i_buffer, i_mix_gain and i_feedback_gain; clear both accumulators (width audio_width+gain_width, signed); set count=0; next state MUL; i_ready=0 from that edge.
- MUL, one step per cycle, LSB first, for bit k=count:
  - if mix_gain[k], acc_mix += sign_extend(buffer) << k;
  - if fb_gain[k], acc_fb += sign_extend(buffer) << k.
  - count increments each cycle; after the step with k=gain_width-1, next state is SUM. Exactly gain_width cycles are spent in MUL.
- SUM (one cycle):
  - wet = acc_mix >>> gain_width and fbk = acc_fb >>> gain_width (arithmetic shift, floor rounding).
  - o_result <= sat(current + wet); o_buffer <= sat(current + fbk).
  - sat clamps to 2^(audio_width-1)-1 and -2^(audio_width-1); sums are computed at audio_width+1 bits.
  - o_valid <= 1; next state OUT.
- OUT:
  - Hold o_valid, o_result and o_buffer stable while o_ready=0.
  - On an edge with o_valid=1 and o_ready=1: o_valid <= 0, i_ready <= 1, next state IDLE.
- Latency: accept at edge T gives o_valid=1 after edge T+gain_width+1 (T+9 at default). Minimum issue interval is gain_width+3 cycles (11 at default).
- Gain ports are sampled only at acceptance; changes during MUL, SUM or OUT have no effect on the current transaction.
- i_valid while i_ready=0 is ignored; the upstream holds it until accepted.
- Gain 0 gives wet=0 and fbk=0, so both outputs equal current, with the same latency.
- Maximum gain 2^gain_width-1 is less than unity. Operand changes after acceptance do not affect the result.

Test Plan:
- Basic mix, default params: current=0x1000, buffer=0x2000, mix=0x80, fb=0x40 → o_result=0x2000, o_buffer=0x1800, o_valid rises 9 cycles after the accept edge.
- Positive saturation: current=0x7000, buffer=0x7000, mix=0xFF, fb=0x00 → wet=0x6F90, o_result=0x7FFF, o_buffer=0x7000.
- Negative saturation and floor rounding:
  - current=0x8000, buffer=0x8000, mix=0xFF → o_result=0x8000.
  - current=0x0000, buffer=0xFFFF, mix=0x80, fb=0x01 → o_result=0xFFFF, o_buffer=0xFFFF.
- Back-pressure: hold o_ready=0 for 5 cycles after o_valid → outputs stable and i_ready=0 throughout; on o_ready=1, one handshake occurs, then i_ready=1 the next cycle. A second pair of operands with different gains is applied and its gains are used only for that transaction.
- Reset mid-MUL: assert reset=0 three cycles after accept → o_valid=0, i_ready=1, outputs 0 immediately. After release, a transaction current=0x0100, buffer=0x0000 returns o_result=0x0100, o_buffer=0x0100.
- Loop with delay buffer (depth 4, mix=0x80, fb=0x80): feed 0x1000,0,0,0,0,0,0,0,0 → o_result sequence 0x1000,0,0,0,0x0800,0,0,0,0x0400.
